frame_stream_builder: RTL and testbench

- Parametrised successor to the fixed 4-channel `data_reader`/`frame_header` pair.
- Runs in the sys_clk domain.
- On a frame-complete pulse it emits a header, then walks every virtual channel and every physical channel. For each (vchn, ch) segment it reads `len` words from that channel's dual-port RAM and streams them out through a valid/ready interface.
- Channel count, virtual channel count, address width and data width are parameters. Per-segment descriptors are optional.

---
 rtl/frame_stream_builder.sv | 217 +++++++++++++++++++++
 tb/tb_frame_stream_builder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_builder.sv
// Frame serialiser: header, then every (vchn, ch) RAM segment, streamed through a 4-deep output FIFO.
// Optional per-segment descriptor words are enabled with `define FRAME_SEG_DESC_EN.
module frame_stream_builder #(
    parameter int          CH_NUM      = 4,
    parameter int          VCHN_W      = 2,
    parameter int          ADDR_W      = 8,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] FRAME_MAGIC = 32'hA55A0F0F
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_complite,
    input  logic [31:0]              i_sync_counter,
    input  logic [31:0]              i_way_meter,
    input  logic [31:0]              i_system_timer,
    output logic [VCHN_W-1:0]        o_rd_vchn,
    input  logic [CH_NUM*ADDR_W-1:0] i_data_len,
    output logic [CH_NUM*ADDR_W-1:0] o_rd_addr,
    input  logic [CH_NUM*DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0]        o_out_data,
    output logic                     o_out_vld,
    input  logic                     i_out_rdy,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [15:0]              o_frame_words,
    output logic                     o_overrun
);
    localparam int         CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [7:0] VCHN_CNT = 8'(2 ** VCHN_W);
    localparam logic [7:0] CH_CNT   = 8'(CH_NUM);

`ifdef FRAME_SEG_DESC_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEL, S_LEN, S_DATA, S_DRAIN, S_DESC} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEL, S_LEN, S_DATA, S_DRAIN} state_t;
`endif

    state_t              state_q;
    logic [15:0]         seq_q, word_cnt_q, frame_words_q;
    logic [31:0]         sync_q, way_q, tmr_q;
    logic [2:0]          hdr_idx_q;
    logic [VCHN_W-1:0]   v_q;
    logic [CH_W-1:0]     ch_q, rd_ch_q;
    logic [ADDR_W-1:0]   len_q, addr_q;
    logic                rd_vld_q, busy_q, done_q, overrun_q;

    logic [DATA_W-1:0]   fifo_mem_q [4];
    logic [1:0]          wr_ptr_q, rd_ptr_q;
    logic [2:0]          cnt_q;

    logic                pop, room, issue, hdr_push, desc_push, push, seg_end, last_ch, last_v;
    logic [DATA_W-1:0]   hdr_word, push_data;
    logic [ADDR_W-1:0]   cur_len;

    always_comb begin
        pop      = (cnt_q != 3'd0) && i_out_rdy;
        room     = (cnt_q != 3'd4) || pop;
        cur_len  = i_data_len[ch_q*ADDR_W +: ADDR_W];
        last_ch  = (ch_q == CH_W'(CH_NUM - 1));
        last_v   = &v_q;
        case (hdr_idx_q)
            3'd0:    hdr_word = DATA_W'(FRAME_MAGIC);
            3'd1:    hdr_word = DATA_W'({seq_q, VCHN_CNT, CH_CNT});
            3'd2:    hdr_word = DATA_W'(sync_q);
            3'd3:    hdr_word = DATA_W'(way_q);
            default: hdr_word = DATA_W'(tmr_q);
        endcase
        // Occupancy counts the read in flight so its data always has a slot.
        issue    = (state_q == S_DATA) && ((cnt_q + {2'b0, rd_vld_q}) < 3'd4);
        hdr_push = (state_q == S_HDR) && room && !rd_vld_q;
`ifdef FRAME_SEG_DESC_EN
        desc_push = (state_q == S_DESC) && room && !rd_vld_q;
`else
        desc_push = 1'b0;
`endif
        push      = rd_vld_q || hdr_push || desc_push;
        push_data = '0;
        if (rd_vld_q)
            push_data = i_rd_data[rd_ch_q*DATA_W +: DATA_W];
        else if (hdr_push)
            push_data = hdr_word;
`ifdef FRAME_SEG_DESC_EN
        else if (desc_push)
            push_data = DATA_W'({8'hC5, 8'(v_q), 8'(ch_q), 8'(len_q)});
`endif
        seg_end = 1'b0;
        case (state_q)
`ifdef FRAME_SEG_DESC_EN
            S_DESC:  seg_end = desc_push && (len_q == '0);
`else
            S_LEN:   seg_end = (cur_len == '0);
`endif
            S_DATA:  seg_end = issue && (addr_q == len_q - 1'b1);
            default: seg_end = 1'b0;
        endcase
    end

    always_comb begin
        o_rd_addr = '0;
        if (state_q == S_DATA)
            o_rd_addr[ch_q*ADDR_W +: ADDR_W] = addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            seq_q         <= '0;
            word_cnt_q    <= '0;
            frame_words_q <= '0;
            sync_q        <= '0;
            way_q         <= '0;
            tmr_q         <= '0;
            hdr_idx_q     <= '0;
            v_q           <= '0;
            ch_q          <= '0;
            rd_ch_q       <= '0;
            len_q         <= '0;
            addr_q        <= '0;
            rd_vld_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= i_complite && (state_q != S_IDLE);
            rd_vld_q  <= issue;
            rd_ch_q   <= ch_q;
            if (push)
                word_cnt_q <= word_cnt_q + 16'd1;
            // Walk order: ch is the inner loop, vchn the outer one.
            if (seg_end) begin
                if (last_ch) begin
                    ch_q <= '0;
                    if (last_v) begin
                        state_q <= S_DRAIN;
                    end else begin
                        v_q     <= v_q + 1'b1;
                        state_q <= S_SEL;
                    end
                end else begin
                    ch_q    <= ch_q + 1'b1;
                    state_q <= S_LEN;
                end
            end
            case (state_q)
                S_IDLE: if (i_complite) begin
                    sync_q     <= i_sync_counter;
                    way_q      <= i_way_meter;
                    tmr_q      <= i_system_timer;
                    hdr_idx_q  <= '0;
                    word_cnt_q <= '0;
                    v_q        <= '0;
                    ch_q       <= '0;
                    busy_q     <= 1'b1;
                    state_q    <= S_HDR;
                end
                S_HDR: if (hdr_push) begin
                    hdr_idx_q <= hdr_idx_q + 3'd1;
                    if (hdr_idx_q == 3'd4)
                        state_q <= S_SEL;
                end
                S_SEL: state_q <= S_LEN;
                S_LEN: begin
                    len_q  <= cur_len;
                    addr_q <= '0;
`ifdef FRAME_SEG_DESC_EN
                    state_q <= S_DESC;
`else
                    if (cur_len != '0)
                        state_q <= S_DATA;
`endif
                end
`ifdef FRAME_SEG_DESC_EN
                S_DESC: if (desc_push && len_q != '0)
                    state_q <= S_DATA;
`endif
                S_DATA: if (issue)
                    addr_q <= addr_q + 1'b1;
                S_DRAIN: if (cnt_q == 3'd0 && !rd_vld_q) begin
                    done_q        <= 1'b1;
                    frame_words_q <= word_cnt_q;
                    seq_q         <= seq_q + 16'd1;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q <= cnt_q + {2'b0, push} - {2'b0, pop};
        end
    end

    assign o_rd_vchn     = v_q;
    assign o_out_vld     = (cnt_q != 3'd0);
    assign o_out_data    = o_out_vld ? fifo_mem_q[rd_ptr_q] : '0;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_frame_words = frame_words_q;
    assign o_overrun     = overrun_q;
endmodule

// File: tb/tb_frame_stream_builder.sv
// Randomised bench for frame_stream_builder: frames are checked word-for-word against a loop-built reference list.
`timescale 1ns/1ps
module tb_frame_stream_builder;
    localparam int CH = 4, VW = 2, AW = 8, DW = 32, NV = 1 << VW;
    localparam logic [31:0] MAGIC = 32'hA55A0F0F;

    logic clk = 1'b0, rst_n = 1'b0, i_complite = 1'b0, i_out_rdy = 1'b0;
    logic [31:0] i_sync_counter = '0, i_way_meter = '0, i_system_timer = '0;
    logic [VW-1:0]    o_rd_vchn;
    logic [CH*AW-1:0] i_data_len, o_rd_addr;
    logic [CH*DW-1:0] i_rd_data;
    logic [DW-1:0]    o_out_data;
    logic             o_out_vld, o_busy, o_done, o_overrun;
    logic [15:0]      o_frame_words;

    frame_stream_builder #(.CH_NUM(CH), .VCHN_W(VW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .i_complite(i_complite),
        .i_sync_counter(i_sync_counter), .i_way_meter(i_way_meter), .i_system_timer(i_system_timer),
        .o_rd_vchn(o_rd_vchn), .i_data_len(i_data_len), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_out_data(o_out_data), .o_out_vld(o_out_vld), .i_out_rdy(i_out_rdy),
        .o_busy(o_busy), .o_done(o_done), .o_frame_words(o_frame_words), .o_overrun(o_overrun));

    always #5 clk = ~clk;

    logic [AW-1:0] len_tab [NV][CH];
    always_comb begin
        i_data_len = '0;
        for (int k = 0; k < CH; k++) i_data_len[k*AW +: AW] = len_tab[o_rd_vchn][k];
    end

    // RAM model: word = {vchn, ch, addr}, one cycle after the address.
    always @(posedge clk) begin
        for (int k = 0; k < CH; k++)
            i_rd_data[k*DW +: DW] <= {8'(o_rd_vchn), 8'(k), 16'(o_rd_addr[k*AW +: AW])};
    end

    int n_chk = 0, n_pass = 0;
    int cyc = 0, done_cnt = 0, ovr_cnt = 0, stab_err = 0;
    logic [15:0] fw_at_done = '0, exp_seq = '0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [31:0] got_q[$], exp_q[$];
    int got_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (o_out_vld !== 1'b1 || o_out_data !== prev_data)) stab_err <= stab_err + 1;
            if (o_out_vld && i_out_rdy) begin got_q.push_back(o_out_data); got_cyc.push_back(cyc); end
            if (o_done) begin done_cnt <= done_cnt + 1; fw_at_done <= o_frame_words; end
            if (o_overrun) ovr_cnt <= ovr_cnt + 1;
            prev_stall <= o_out_vld && !i_out_rdy;
            prev_data  <= o_out_data;
        end
    end

    int rdy_mode = 0, phase = 0, stall_left = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: i_out_rdy = 1'b1;
            1: i_out_rdy = 1'($urandom_range(0, 1));
            default: begin
                if (phase < 8) i_out_rdy = (phase % 2 == 0);
                else if (stall_left > 0) begin i_out_rdy = 1'b0; stall_left--; end
                else if ($urandom_range(0, 3) == 0) begin i_out_rdy = 1'b0; stall_left = 2; end
                else i_out_rdy = 1'b1;
                phase = (phase + 1) % 20;
            end
        endcase
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic build_exp(input logic [15:0] sq, input logic [31:0] s, input logic [31:0] w, input logic [31:0] t);
        exp_q.delete();
        exp_q.push_back(MAGIC);
        exp_q.push_back({sq, 8'(NV), 8'(CH)});
        exp_q.push_back(s); exp_q.push_back(w); exp_q.push_back(t);
        for (int v = 0; v < NV; v++)
            for (int c = 0; c < CH; c++) begin
`ifdef FRAME_SEG_DESC_EN
                exp_q.push_back({8'hC5, 8'(v), 8'(c), 8'(len_tab[v][c])});
`endif
                for (int a = 0; a < int'(len_tab[v][c]); a++) exp_q.push_back({8'(v), 8'(c), 16'(a)});
            end
    endtask

    function automatic int first_diff();
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        return (got_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    function automatic logic [31:0] gw(input int i);
        return (i >= 0 && i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] ew(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 32'hxxxxxxxx;
    endfunction

    task automatic set_lens(input int maxlen);
        for (int v = 0; v < NV; v++)
            for (int c = 0; c < CH; c++) len_tab[v][c] = AW'($urandom_range(0, maxlen));
    endtask

    task automatic start_frame();
        i_sync_counter = $urandom; i_way_meter = $urandom; i_system_timer = $urandom;
        got_q.delete(); got_cyc.delete();
        build_exp(exp_seq, i_sync_counter, i_way_meter, i_system_timer);
        @(posedge clk); #1 i_complite = 1'b1;
        @(posedge clk); #1 i_complite = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        int d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_addr(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (o_rd_addr != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_lens(0);
        repeat (3) @(posedge clk); #1;
        n_chk++; if (o_out_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", o_out_vld); else n_pass++;
        n_chk++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
        n_chk++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else n_pass++;
        n_chk++; if (o_overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", o_overrun); else n_pass++;
        n_chk++; if (o_frame_words !== 16'h0) $display("FAIL reset_fw: got %h want 0", o_frame_words); else n_pass++;
        n_chk++; if (o_rd_addr !== '0) $display("FAIL reset_addr: got %h want 0", o_rd_addr); else n_pass++;
        n_chk++; if (o_rd_vchn !== '0) $display("FAIL reset_vchn: got %h want 0", o_rd_vchn); else n_pass++;
        n_chk++; if (o_out_data !== '0) $display("FAIL reset_data: got %h want 0", o_out_data); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_chk++; if (o_busy !== 1'b0 || o_out_vld !== 1'b0) $display("FAIL idle_after_reset: busy %b vld %b want 0 0", o_busy, o_out_vld); else n_pass++;
    endtask

    task automatic test_minimal();
        bit ok; int d; int d0; logic [31:0] w1;
        rdy_mode = 0; set_lens(0);
        d0 = done_cnt;
        start_frame();
        n_chk++; if (o_busy !== 1'b1) $display("FAIL min_busy: got %b want 1", o_busy); else n_pass++;
        wait_done(500, ok);
        n_chk++; if (!ok) $display("FAIL min_timeout: got no o_done want o_done"); else n_pass++;
        d = first_diff();
        n_chk++; if (d != -1) $display("FAIL min_seq: word %0d got %h want %h (got %0d words want %0d)", d, gw(d), ew(d), got_q.size(), exp_q.size()); else n_pass++;
        w1 = gw(1);
        n_chk++; if (w1 !== 32'h00000404) $display("FAIL min_word1: got %h want 00000404", w1); else n_pass++;
`ifdef FRAME_SEG_DESC_EN
        n_chk++; if (fw_at_done !== 16'd21) $display("FAIL min_fw: got %0d want 21", fw_at_done); else n_pass++;
`else
        n_chk++; if (fw_at_done !== 16'd5) $display("FAIL min_fw: got %0d want 5", fw_at_done); else n_pass++;
`endif
        n_chk++; if (o_busy !== 1'b0) $display("FAIL min_busy_clr: got %b want 0", o_busy); else n_pass++;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (done_cnt - d0 != 1) $display("FAIL min_done_once: got %0d pulse cycles want 1", done_cnt - d0); else n_pass++;
        exp_seq++;
    endtask

    task automatic test_data_walk();
        bit ok; int d; int idx; int gap;
        rdy_mode = 0; set_lens(0); len_tab[2][1] = 8'd3;
        start_frame();
        wait_done(500, ok);
        n_chk++; if (!ok) $display("FAIL walk_timeout: got no o_done want o_done"); else n_pass++;
        d = first_diff();
        n_chk++; if (d != -1) $display("FAIL walk_seq: word %0d got %h want %h (got %0d words want %0d)", d, gw(d), ew(d), got_q.size(), exp_q.size()); else n_pass++;
        n_chk++; if (fw_at_done !== 16'(exp_q.size())) $display("FAIL walk_fw: got %0d want %0d", fw_at_done, exp_q.size()); else n_pass++;
        idx = -1;
        foreach (exp_q[i]) if (exp_q[i] == 32'h02010000) idx = i;
        gap = (idx >= 0 && got_cyc.size() > idx + 2) ? got_cyc[idx+2] - got_cyc[idx] : -1;
        n_chk++; if (gap != 2) $display("FAIL walk_bubble: got %0d cycles for 3 words want 2", gap); else n_pass++;
        exp_seq++;
    endtask

    task automatic test_backpressure();
        bit ok; int d; int s0;
        rdy_mode = 2; phase = 0; set_lens(0); len_tab[2][1] = 8'd3;
        s0 = stab_err;
        start_frame();
        wait_done(1000, ok);
        n_chk++; if (!ok) $display("FAIL bp_timeout: got no o_done want o_done"); else n_pass++;
        d = first_diff();
        n_chk++; if (d != -1) $display("FAIL bp_seq: word %0d got %h want %h (got %0d words want %0d)", d, gw(d), ew(d), got_q.size(), exp_q.size()); else n_pass++;
`ifndef FRAME_SEG_DESC_EN
        n_chk++; if (fw_at_done !== 16'd8) $display("FAIL bp_fw: got %0d want 8", fw_at_done); else n_pass++;
`else
        n_chk++; if (fw_at_done !== 16'd24) $display("FAIL bp_fw: got %0d want 24", fw_at_done); else n_pass++;
`endif
        n_chk++; if (stab_err != s0) $display("FAIL bp_stable: got %0d head changes while stalled want 0", stab_err - s0); else n_pass++;
        exp_seq++;
    endtask

    task automatic test_random();
        bit ok; int d; int s0;
        for (int f = 0; f < 3; f++) begin
            rdy_mode = (f == 1) ? 2 : 1; set_lens(5);
            s0 = stab_err;
            start_frame();
            wait_done(3000, ok);
            n_chk++; if (!ok) $display("FAIL rnd%0d_timeout: got no o_done want o_done", f); else n_pass++;
            d = first_diff();
            n_chk++; if (d != -1) $display("FAIL rnd%0d_seq: word %0d got %h want %h (got %0d words want %0d)", f, d, gw(d), ew(d), got_q.size(), exp_q.size()); else n_pass++;
            n_chk++; if (fw_at_done !== 16'(exp_q.size())) $display("FAIL rnd%0d_fw: got %0d want %0d", f, fw_at_done, exp_q.size()); else n_pass++;
            n_chk++; if (stab_err != s0) $display("FAIL rnd%0d_stable: got %0d head changes want 0", f, stab_err - s0); else n_pass++;
            exp_seq++;
        end
    endtask

    task automatic test_overrun();
        bit ok; int d; int o0;
        rdy_mode = 1; set_lens(3); len_tab[0][0] = 8'd4;
        o0 = ovr_cnt;
        start_frame();
        wait_addr(200, ok);
        n_chk++; if (!ok) $display("FAIL ovr_reach_data: got no read address want one"); else n_pass++;
        i_sync_counter = ~i_sync_counter;
        @(posedge clk); #1 i_complite = 1'b1;
        @(posedge clk); #1 i_complite = 1'b0;
        wait_done(3000, ok);
        n_chk++; if (!ok) $display("FAIL ovr_timeout: got no o_done want o_done"); else n_pass++;
        n_chk++; if (ovr_cnt - o0 != 1) $display("FAIL ovr_pulse: got %0d pulse cycles want 1", ovr_cnt - o0); else n_pass++;
        d = first_diff();
        n_chk++; if (d != -1) $display("FAIL ovr_seq: word %0d got %h want %h (got %0d words want %0d)", d, gw(d), ew(d), got_q.size(), exp_q.size()); else n_pass++;
        n_chk++; if (fw_at_done !== 16'(exp_q.size())) $display("FAIL ovr_fw: got %0d want %0d", fw_at_done, exp_q.size()); else n_pass++;
        exp_seq++;
    endtask

    task automatic test_seq_wrap();
        bit ok; logic [31:0] w1;
        rdy_mode = 0; set_lens(0);
        force dut.seq_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.seq_q;
        exp_seq = 16'hFFFF;
        start_frame();
        wait_done(500, ok);
        w1 = gw(1);
        n_chk++; if (!ok || w1[31:16] !== 16'hFFFF) $display("FAIL wrap_hi: got %h (done %0d) want FFFF", w1[31:16], ok); else n_pass++;
        exp_seq++;
        start_frame();
        wait_done(500, ok);
        w1 = gw(1);
        n_chk++; if (!ok || w1[31:16] !== 16'h0000) $display("FAIL wrap_lo: got %h (done %0d) want 0000", w1[31:16], ok); else n_pass++;
        exp_seq++;
    endtask

    task automatic test_reset_abort();
        bit ok; int d; int d0;
        rdy_mode = 2; phase = 0; set_lens(2); len_tab[0][1] = 8'd6; len_tab[1][2] = 8'd5;
        d0 = done_cnt;
        start_frame();
        wait_addr(300, ok);
        n_chk++; if (!ok) $display("FAIL abort_reach_data: got no read address want one"); else n_pass++;
        rst_n = 1'b0; #1;
        n_chk++; if (o_out_vld !== 1'b0 || o_busy !== 1'b0) $display("FAIL abort_out: vld %b busy %b want 0 0", o_out_vld, o_busy); else n_pass++;
        n_chk++; if (o_rd_addr !== '0) $display("FAIL abort_addr: got %h want 0", o_rd_addr); else n_pass++;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        n_chk++; if (done_cnt != d0) $display("FAIL abort_no_done: got %0d done pulses want 0", done_cnt - d0); else n_pass++;
        exp_seq = 16'h0;
        rdy_mode = 1;
        start_frame();
        wait_done(3000, ok);
        n_chk++; if (!ok) $display("FAIL abort_next_timeout: got no o_done want o_done"); else n_pass++;
        d = first_diff();
        n_chk++; if (d != -1) $display("FAIL abort_next_seq: word %0d got %h want %h (got %0d words want %0d)", d, gw(d), ew(d), got_q.size(), exp_q.size()); else n_pass++;
        n_chk++; if (fw_at_done !== 16'(exp_q.size())) $display("FAIL abort_next_fw: got %0d want %0d", fw_at_done, exp_q.size()); else n_pass++;
        exp_seq++;
    endtask

    initial begin
        test_reset();
        test_minimal();
        test_data_walk();
        test_backpressure();
        test_random();
        test_overrun();
        test_seq_wrap();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
